// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-control bundle between the control unit/decode stage and
// the program-counter generator. "master" drives stall/flush/branch requests,
// "slave" (pc_gen) returns the fetch address and status.
interface pc_gen_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [5:0]        stall;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic              branch_flag_i;
  logic [ADDR_W-1:0] branch_target_address_i;
  logic [ADDR_W-1:0] pc;
  logic              ce;
  logic              redirect_pending;
  logic              misalign_o;

  modport master (
    output stall, flush, new_pc, branch_flag_i, branch_target_address_i,
    input  pc, ce, redirect_pending, misalign_o
  );

  modport slave (
    input  stall, flush, new_pc, branch_flag_i, branch_target_address_i,
    output pc, ce, redirect_pending, misalign_o
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch program counter with boot delay, flush/branch redirect and
// capture of branches that arrive while fetch is stalled.
// Optional feature macro: PC_ALIGN_CHECK_EN -- aligns redirect targets to STEP
// and pulses misalign_o when a target had low bits set.
module pc_gen #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int unsigned       STEP        = 4,
  parameter int unsigned       BOOT_CYCLES = 1
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);

  typedef enum logic {S_BOOT, S_RUN} state_t;

  localparam logic [3:0]        BOOT_LAST = 4'(BOOT_CYCLES);
  localparam logic [ADDR_W-1:0] STEP_INC  = ADDR_W'(STEP);

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_paddr, w_paddr_nxt;
  logic              r_ce, w_ce_nxt;
  logic              r_pend, w_pend_nxt;
  logic              r_mis, w_mis_nxt;

  logic [ADDR_W-1:0] w_flush_tgt, w_br_tgt;
  logic              w_flush_mis, w_br_mis;
  logic              w_stall;
  logic              w_unused_stall;

  assign w_stall        = bus.stall[0];
  assign w_unused_stall = ^bus.stall[5:1];

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);

  assign w_flush_tgt = bus.new_pc & ~ALIGN_MASK;
  assign w_flush_mis = |(bus.new_pc & ALIGN_MASK);
  assign w_br_tgt    = bus.branch_target_address_i & ~ALIGN_MASK;
  assign w_br_mis    = |(bus.branch_target_address_i & ALIGN_MASK);
`else
  assign w_flush_tgt = bus.new_pc;
  assign w_flush_mis = 1'b0;
  assign w_br_tgt    = bus.branch_target_address_i;
  assign w_br_mis    = 1'b0;
`endif

  // State register: BOOT until the boot counter expires, then RUN until reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_BOOT;
    else      r_state <= w_state_nxt;
  end

  // Next-state and datapath decode; RUN follows flush > stalled capture >
  // live branch > pending redirect > sequential increment
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ce_nxt    = r_ce;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend;
    w_paddr_nxt = r_paddr;
    w_mis_nxt   = 1'b0;
    unique case (r_state)
      S_BOOT: begin
        w_cnt_nxt = r_cnt + 4'd1;
        if (w_cnt_nxt == BOOT_LAST) begin
          w_state_nxt = S_RUN;
          w_ce_nxt    = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.flush) begin
          w_pc_nxt    = w_flush_tgt;
          w_mis_nxt   = w_flush_mis;
          w_pend_nxt  = 1'b0;
          w_paddr_nxt = '0;
        end else if (w_stall) begin
          if (bus.branch_flag_i) begin
            w_paddr_nxt = w_br_tgt;
            w_pend_nxt  = 1'b1;
            w_mis_nxt   = w_br_mis;
          end
        end else if (bus.branch_flag_i) begin
          w_pc_nxt    = w_br_tgt;
          w_mis_nxt   = w_br_mis;
          w_pend_nxt  = 1'b0;
          w_paddr_nxt = '0;
        end else if (r_pend) begin
          // Pending address was already aligned when captured
          w_pc_nxt    = r_paddr;
          w_pend_nxt  = 1'b0;
          w_paddr_nxt = '0;
        end else begin
          w_pc_nxt = r_pc + STEP_INC;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  // Datapath registers: PC, boot counter, chip enable, pending redirect, fault pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_pc    <= RESET_VEC;
      r_ce    <= 1'b0;
      r_pend  <= 1'b0;
      r_paddr <= '0;
      r_mis   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_pc    <= w_pc_nxt;
      r_ce    <= w_ce_nxt;
      r_pend  <= w_pend_nxt;
      r_paddr <= w_paddr_nxt;
      r_mis   <= w_mis_nxt;
    end
  end

  assign bus.pc               = r_pc;
  assign bus.ce               = r_ce;
  assign bus.redirect_pending = r_pend;
  assign bus.misalign_o       = r_mis;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: randomized and directed stimulus for pc_gen, checked against a
// behavioural model. Two instances: 32-bit with a 3-cycle boot, and an 8-bit
// one left free-running to exercise wrap-around.
module tb_pc_gen;

  logic clk;
  logic rst;
  int unsigned n_checks;
  int unsigned n_errors;

  pc_gen_if #(.ADDR_W(32)) if32 ();
  pc_gen_if #(.ADDR_W(8))  if8 ();

  pc_gen #(
    .ADDR_W(32), .RESET_VEC(32'h0), .STEP(4), .BOOT_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst), .bus(if32)
  );

  pc_gen #(
    .ADDR_W(8), .RESET_VEC(8'h0), .STEP(4), .BOOT_CYCLES(1)
  ) dut8 (
    .clk(clk), .rst(rst), .bus(if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint unsigned pc;
    bit              ce;
    bit              pend;
    longint unsigned paddr;
    bit              mis;
    int              boot_left;
  } mdl_t;

  mdl_t m32, m8;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic mdl_t mdl_reset(input int boot);
    mdl_t m;
    m.pc = 0; m.ce = 0; m.pend = 0; m.paddr = 0; m.mis = 0; m.boot_left = boot;
    return m;
  endfunction

  // Target as loaded into pc/pending: rounded down to a STEP multiple when alignment checking is built in
  function automatic longint unsigned fix_tgt(input longint unsigned a, input longint unsigned step);
`ifdef PC_ALIGN_CHECK_EN
    return a - (a % step);
`else
    return a;
`endif
  endfunction

  function automatic bit bad_tgt(input longint unsigned a, input longint unsigned step);
`ifdef PC_ALIGN_CHECK_EN
    return (a % step) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic mdl_t mdl_next(input mdl_t m, input int aw, input longint unsigned step,
                                    input bit s0, input bit fl, input longint unsigned npc,
                                    input bit br, input longint unsigned bt);
    mdl_t n = m;
    longint unsigned modulus = 64'd1 << aw;
    n.mis = 0;
    if (m.boot_left > 0) begin
      n.boot_left = m.boot_left - 1;
      if (n.boot_left == 0) n.ce = 1;
      return n;
    end
    if (fl) begin
      n.pc = fix_tgt(npc, step); n.mis = bad_tgt(npc, step); n.pend = 0;
    end else if (s0) begin
      if (br) begin
        n.paddr = fix_tgt(bt, step); n.mis = bad_tgt(bt, step); n.pend = 1;
      end
    end else if (br) begin
      n.pc = fix_tgt(bt, step); n.mis = bad_tgt(bt, step); n.pend = 0;
    end else if (m.pend) begin
      n.pc = m.paddr; n.pend = 0;
    end else begin
      n.pc = (m.pc + step) % modulus;
    end
    return n;
  endfunction

  task automatic compare_all();
    check("pc32",   64'(if32.pc), m32.pc);
    check("ce32",   64'(if32.ce), 64'(m32.ce));
    check("pend32", 64'(if32.redirect_pending), 64'(m32.pend));
    check("mis32",  64'(if32.misalign_o), 64'(m32.mis));
    check("pc8",    64'(if8.pc), m8.pc);
    check("ce8",    64'(if8.ce), 64'(m8.ce));
    check("pend8",  64'(if8.redirect_pending), 64'(m8.pend));
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge, check 1ns later
  task automatic cycle(input bit r, input bit s0, input logic [4:0] shi, input bit fl,
                       input logic [31:0] npc, input bit br, input logic [31:0] bt);
    @(negedge clk);
    rst                          = r;
    if32.stall                   = {shi, s0};
    if32.flush                   = fl;
    if32.new_pc                  = npc;
    if32.branch_flag_i           = br;
    if32.branch_target_address_i = bt;
    @(posedge clk);
    if (!rst) begin
      m32 = mdl_reset(3);
      m8  = mdl_reset(1);
    end else begin
      m32 = mdl_next(m32, 32, 4, s0, fl, longint'(npc), br, longint'(bt));
      m8  = mdl_next(m8, 8, 4, 1'b0, 1'b0, 0, 1'b0, 0);
    end
    #1;
    compare_all();
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic rand_cycle();
    bit s0, fl, br;
    logic [31:0] npc, bt;
    s0  = ($urandom_range(0, 99) < 35);
    fl  = ($urandom_range(0, 99) < 8);
    br  = ($urandom_range(0, 99) < 25);
    npc = $urandom;
    bt  = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      npc[1:0] = 2'b00;
      bt[1:0]  = 2'b00;
    end
    cycle(1'b1, s0, 5'($urandom), fl, npc, br, bt);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst  = 1'b0;
    m32  = mdl_reset(3);
    m8   = mdl_reset(1);
    if32.stall = '0; if32.flush = 1'b0; if32.new_pc = '0;
    if32.branch_flag_i = 1'b0; if32.branch_target_address_i = '0;
    if8.stall = '0; if8.flush = 1'b0; if8.new_pc = '0;
    if8.branch_flag_i = 1'b0; if8.branch_target_address_i = '0;

    // Reset held, then boot with requests that must be ignored
    cycle(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 5'h1f, 1'b1, 32'h500, 1'b1, 32'h600);
    cycle(1'b1, 1'b0, 5'd0, 1'b1, 32'h500, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 5'd3, 1'b0, 32'h0, 1'b1, 32'h700);
    cycle(1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 32'h800);
    check("boot_ce_rise", 64'(if32.ce), 64'd1);
    idle(); idle(); idle();
    check("boot_pc_seq", 64'(if32.pc), 64'hC);

    // Stalled branch captured and applied on release
    cycle(1'b1, 1'b0, 5'd0, 1'b1, 32'h100, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 5'd0, 1'b0, 32'h0, 1'b1, 32'h2000);
    cycle(1'b1, 1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("stall_hold_pc", 64'(if32.pc), 64'h100);
    check("stall_pending", 64'(if32.redirect_pending), 64'd1);
    idle();
    check("release_pc", 64'(if32.pc), 64'h2000);
    idle();
    check("release_next", 64'(if32.pc), 64'h2004);

    // Flush beats stall, branch and an existing pending redirect
    cycle(1'b1, 1'b1, 5'd0, 1'b0, 32'h0, 1'b1, 32'h900);
    cycle(1'b1, 1'b1, 5'd0, 1'b1, 32'h80, 1'b1, 32'h300);
    check("prio_pc", 64'(if32.pc), 64'h80);
    check("prio_pend", 64'(if32.redirect_pending), 64'd0);

    // Misaligned branch target
    cycle(1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 32'h1006);
    idle();

    // Random traffic; the 8-bit instance wraps several times meanwhile
    for (int unsigned i = 0; i < 400; i++) rand_cycle();

    // Asynchronous reset between edges with a pending redirect
    cycle(1'b1, 1'b1, 5'd0, 1'b0, 32'h0, 1'b1, 32'h4440);
    #2;
    rst = 1'b0;
    #1;
    m32 = mdl_reset(3);
    m8  = mdl_reset(1);
    compare_all();
    cycle(1'b0, 1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int unsigned i = 0; i < 150; i++) rand_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
